// File: rtl/rv32i_multicycle_seq_if.sv
// Memory handshake bundle between the multicycle sequencer and the
// instruction/data memories.
//   imem_req   : instruction fetch request        (sequencer -> memory)
//   imem_ready : instruction data valid           (memory -> sequencer)
//   dmem_req   : data memory request              (sequencer -> memory)
//   dmem_we    : data memory write (store)        (sequencer -> memory)
//   dmem_ready : data access complete             (memory -> sequencer)
interface rv32i_multicycle_seq_if;
    logic imem_req;
    logic imem_ready;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ready;

    modport master (
        output imem_req,
        output dmem_req,
        output dmem_we,
        input  imem_ready,
        input  dmem_ready
    );

    modport slave (
        input  imem_req,
        input  dmem_req,
        input  dmem_we,
        output imem_ready,
        output dmem_ready
    );
endinterface

// File: rtl/rv32i_multicycle_seq.sv
// Control sequencer for the multicycle RV32I core. Each instruction walks
// FETCH -> DECODE -> EXEC -> [MEM] -> [WB] and the sequencer drives the
// PC / IR / register-file / data-memory enables. Memory handshakes are
// req/ready with variable latency and an optional timeout into TRAP.
// Ports:
//   clock, reset       : clock and synchronous active-high reset
//   mem                : imem/dmem handshake bundle (master side)
//   opcode             : instr[6:0] from the IR, valid from DECODE onward
//   branch_taken       : branch compare result, used in EXEC
//   ir_write, rd_write,
//   pc_write, pc_sel   : datapath enables (pc_sel 0 = PC+4, 1 = ALU result)
//   state              : FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 TRAP=7
//   halted, trap_cause : TRAP indication and reason
//   cycle_cnt          : non-halted cycles since reset
//   instret_cnt        : retired instructions
module rv32i_multicycle_seq #(
    parameter int CNT_WIDTH = 32,
    parameter int TIMEOUT   = 16,
    parameter int TO_WIDTH  = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    rv32i_multicycle_seq_if.master    mem,
    input  logic [6:0]                opcode,
    input  logic                      branch_taken,
    output logic                      ir_write,
    output logic                      rd_write,
    output logic                      pc_write,
    output logic                      pc_sel,
    output logic [2:0]                state,
    output logic                      halted,
    output logic [1:0]                trap_cause,
    output logic [CNT_WIDTH-1:0]      cycle_cnt,
    output logic [CNT_WIDTH-1:0]      instret_cnt
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU,      // LUI, AUIPC, OP-IMM, OP
        CLS_JUMP,     // JAL, JALR: writeback selects ALU target for PC
        CLS_BRANCH,
        CLS_LOAD,
        CLS_STORE,
        CLS_SYSTEM,
        CLS_ILLEGAL
    } cls_t;

    localparam bit                TO_EN    = (TIMEOUT != 0);
    localparam logic [TO_WIDTH-1:0] TO_LIMIT = TO_WIDTH'(TIMEOUT);

    state_t              state_q;
    cls_t                cls_q;
    cls_t                cls_d;
    logic [TO_WIDTH-1:0] wait_cnt;
    logic                wait_expired;
    logic                retire;

    function automatic cls_t decode_class(input logic [6:0] op);
        cls_t c;
        case (op)
            7'b0110111, 7'b0010111,
            7'b0010011, 7'b0110011: c = CLS_ALU;
            7'b1101111, 7'b1100111: c = CLS_JUMP;
            7'b1100011:             c = CLS_BRANCH;
            7'b0000011:             c = CLS_LOAD;
            7'b0100011:             c = CLS_STORE;
            7'b1110011:             c = CLS_SYSTEM;
            default:                c = CLS_ILLEGAL;
        endcase
        return c;
    endfunction

    assign cls_d        = decode_class(opcode);
    assign wait_expired = TO_EN && (wait_cnt == TO_LIMIT);
    assign state        = state_q;
    assign halted       = (state_q == S_TRAP);

    // Moore strobes from state/class plus same-cycle ready and branch_taken.
    // Commit strobes are held off while reset is asserted so an aborted
    // instruction never updates architectural state.
    always_comb begin
        mem.imem_req = 1'b0;
        mem.dmem_req = 1'b0;
        mem.dmem_we  = 1'b0;
        ir_write     = 1'b0;
        rd_write     = 1'b0;
        pc_write     = 1'b0;
        pc_sel       = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                mem.imem_req = 1'b1;
                ir_write     = mem.imem_ready && !reset;
            end
            S_EXEC: begin
                if (cls_q == CLS_BRANCH) begin
                    pc_write = !reset;
                    pc_sel   = branch_taken;
                end
            end
            S_MEM: begin
                mem.dmem_req = 1'b1;
                mem.dmem_we  = (cls_q == CLS_STORE);
                if (cls_q == CLS_STORE && mem.dmem_ready) begin
                    pc_write = !reset;
                end
            end
            S_WB: begin
                rd_write = !reset;
                pc_write = !reset;
                pc_sel   = (cls_q == CLS_JUMP);
            end
            default: ;
        endcase
    end

    // Every retirement is exactly a PC update.
    assign retire = pc_write;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_FETCH;
            cls_q       <= CLS_ALU;
            trap_cause  <= 2'b00;
            cycle_cnt   <= '0;
            instret_cnt <= '0;
            wait_cnt    <= '0;
        end else begin
            if (state_q != S_TRAP) begin
                cycle_cnt <= cycle_cnt + CNT_WIDTH'(1);
            end
            if (retire) begin
                instret_cnt <= instret_cnt + CNT_WIDTH'(1);
            end
            unique case (state_q)
                S_FETCH: begin
                    // Ready on the cycle the count hits the limit still wins.
                    if (mem.imem_ready) begin
                        state_q  <= S_DECODE;
                        wait_cnt <= '0;
                    end else if (wait_expired) begin
                        state_q    <= S_TRAP;
                        trap_cause <= 2'b10;
                    end else begin
                        wait_cnt <= wait_cnt + TO_WIDTH'(1);
                    end
                end
                S_DECODE: begin
                    cls_q <= cls_d;
                    if (cls_d == CLS_SYSTEM) begin
                        state_q    <= S_TRAP;
                        trap_cause <= 2'b00;
                    end else if (cls_d == CLS_ILLEGAL) begin
                        state_q    <= S_TRAP;
                        trap_cause <= 2'b01;
                    end else begin
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    wait_cnt <= '0;
                    if (cls_q == CLS_BRANCH) begin
                        state_q <= S_FETCH;
                    end else if (cls_q == CLS_LOAD || cls_q == CLS_STORE) begin
                        state_q <= S_MEM;
                    end else begin
                        state_q <= S_WB;
                    end
                end
                S_MEM: begin
                    if (mem.dmem_ready) begin
                        state_q  <= (cls_q == CLS_STORE) ? S_FETCH : S_WB;
                        wait_cnt <= '0;
                    end else if (wait_expired) begin
                        state_q    <= S_TRAP;
                        trap_cause <= 2'b11;
                    end else begin
                        wait_cnt <= wait_cnt + TO_WIDTH'(1);
                    end
                end
                S_WB: begin
                    state_q  <= S_FETCH;
                    wait_cnt <= '0;
                end
                default: begin
                    // TRAP holds until reset.
                    state_q <= S_TRAP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv32i_multicycle_seq.sv
module tb_rv32i_multicycle_seq;

    localparam int CNT_WIDTH = 32;
    localparam int TIMEOUT   = 16;
    localparam int TO_WIDTH  = 8;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [2:0] st;
        logic       imem_req;
        logic       ir_write;
        logic       dmem_req;
        logic       dmem_we;
        logic       rd_write;
        logic       pc_write;
        logic       pc_sel;
        logic       halted;
    } exp_t;

    logic                 clock = 1'b0;
    logic                 reset;
    logic [6:0]           opcode;
    logic                 branch_taken;
    logic                 ir_write, rd_write, pc_write, pc_sel, halted;
    logic [2:0]           state;
    logic [1:0]           trap_cause;
    logic [CNT_WIDTH-1:0] cycle_cnt, instret_cnt;

    rv32i_multicycle_seq_if bus();

    rv32i_multicycle_seq #(
        .CNT_WIDTH(CNT_WIDTH),
        .TIMEOUT  (TIMEOUT),
        .TO_WIDTH (TO_WIDTH)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .mem         (bus),
        .opcode      (opcode),
        .branch_taken(branch_taken),
        .ir_write    (ir_write),
        .rd_write    (rd_write),
        .pc_write    (pc_write),
        .pc_sel      (pc_sel),
        .state       (state),
        .halted      (halted),
        .trap_cause  (trap_cause),
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: expected outputs for the current cycle plus
    // architectural counters accumulated from the expected traces.
    exp_t       exp_cur;
    bit         exp_valid = 1'b0;
    int         exp_cyc, exp_ins;
    logic [1:0] exp_tc;
    int         m_cycle   = 0;
    int         m_instret = 0;
    logic [1:0] m_cause   = 2'b00;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t mk(input logic [2:0] st, input logic ireq, input logic irw,
                                input logic dreq, input logic dwe, input logic rdw,
                                input logic pcw, input logic pcs);
        exp_t e;
        e.st       = st;
        e.imem_req = ireq;
        e.ir_write = irw;
        e.dmem_req = dreq;
        e.dmem_we  = dwe;
        e.rd_write = rdw;
        e.pc_write = pcw;
        e.pc_sel   = pcs;
        e.halted   = (st == 3'd7);
        return e;
    endfunction

    // Compare process: every cycle with an expectation, mid-cycle.
    always @(negedge clock) begin
        if (exp_valid) begin
            chk("state",       64'(state),        64'(exp_cur.st));
            chk("imem_req",    64'(bus.imem_req), 64'(exp_cur.imem_req));
            chk("ir_write",    64'(ir_write),     64'(exp_cur.ir_write));
            chk("dmem_req",    64'(bus.dmem_req), 64'(exp_cur.dmem_req));
            chk("dmem_we",     64'(bus.dmem_we),  64'(exp_cur.dmem_we));
            chk("rd_write",    64'(rd_write),     64'(exp_cur.rd_write));
            chk("pc_write",    64'(pc_write),     64'(exp_cur.pc_write));
            if (exp_cur.pc_write || exp_cur.rd_write)
                chk("pc_sel",  64'(pc_sel),       64'(exp_cur.pc_sel));
            chk("halted",      64'(halted),       64'(exp_cur.halted));
            chk("trap_cause",  64'(trap_cause),   64'(exp_tc));
            chk("cycle_cnt",   64'(cycle_cnt),    64'(exp_cyc));
            chk("instret_cnt", 64'(instret_cnt),  64'(exp_ins));
        end
    end

    // One clock cycle: apply inputs, publish expectation, advance the model.
    task automatic step(input exp_t e, input bit ir, input bit dr, input bit rst);
        reset          = rst;
        bus.imem_ready = ir;
        bus.dmem_ready = dr;
        exp_cur   = e;
        exp_cyc   = m_cycle;
        exp_ins   = m_instret;
        exp_tc    = m_cause;
        exp_valid = 1'b1;
        @(posedge clock);
        #1;
        if (rst) begin
            m_cycle   = 0;
            m_instret = 0;
            m_cause   = 2'b00;
        end else begin
            if (e.st != 3'd7) m_cycle++;
            if (e.pc_write)   m_instret++;
        end
    endtask

    // Expected trace of one instruction from the latency rules.
    // iw/dw: wait cycles before imem/dmem ready; above TIMEOUT means stuck.
    task automatic instr(input logic [6:0] op, input bit br, input int iw, input int dw);
        bit is_store, is_load, is_jump, legal;
        opcode       = op;
        branch_taken = br;
        is_store = (op == OP_STORE);
        is_load  = (op == OP_LOAD);
        is_jump  = (op == OP_JAL) || (op == OP_JALR);
        legal    = (op == OP_LUI) || (op == OP_AUIPC) || is_jump || (op == OP_BRANCH) ||
                   is_load || is_store || (op == OP_IMM) || (op == OP_OP);
        if (iw > TIMEOUT) begin
            repeat (TIMEOUT + 1) step(mk(3'd0, 1, 0, 0, 0, 0, 0, 0), 0, 1, 0);
            m_cause = 2'b10;
            return;
        end
        repeat (iw) step(mk(3'd0, 1, 0, 0, 0, 0, 0, 0), 0, 1, 0);
        step(mk(3'd0, 1, 1, 0, 0, 0, 0, 0), 1, 1, 0);
        step(mk(3'd1, 0, 0, 0, 0, 0, 0, 0), 1, 1, 0);
        if (op == OP_SYSTEM) begin
            m_cause = 2'b00;
            return;
        end
        if (!legal) begin
            m_cause = 2'b01;
            return;
        end
        if (op == OP_BRANCH) begin
            step(mk(3'd2, 0, 0, 0, 0, 0, 1, br), 1, 1, 0);
            return;
        end
        step(mk(3'd2, 0, 0, 0, 0, 0, 0, 0), 1, 1, 0);
        if (is_load || is_store) begin
            if (dw > TIMEOUT) begin
                repeat (TIMEOUT + 1) step(mk(3'd3, 0, 0, 1, is_store, 0, 0, 0), 1, 0, 0);
                m_cause = 2'b11;
                return;
            end
            repeat (dw) step(mk(3'd3, 0, 0, 1, is_store, 0, 0, 0), 1, 0, 0);
            step(mk(3'd3, 0, 0, 1, is_store, 0, is_store, 0), 1, 1, 0);
            if (is_store) return;
        end
        step(mk(3'd4, 0, 0, 0, 0, 1, 1, is_jump), 1, 1, 0);
    endtask

    task automatic trap_hold(input int n);
        repeat (n) step(mk(3'd7, 0, 0, 0, 0, 0, 0, 0), 1, 1, 0);
    endtask

    task automatic do_reset(input logic [2:0] cur_st);
        exp_t e;
        e = mk(cur_st, 0, 0, 0, 0, 0, 0, 0);
        if (cur_st == 3'd0) e.imem_req = 1'b1;
        step(e, 1, 1, 1);
    endtask

    initial begin
        reset          = 1'b1;
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        opcode         = 7'b0;
        branch_taken   = 1'b0;
        @(posedge clock);
        #1;
        do_reset(3'd0);

        // ADD: 4 cycles, retires once.
        instr(OP_OP, 0, 0, 0);
        chk("add_cycle_cnt", 64'(cycle_cnt), 64'd4);
        chk("add_instret",   64'(instret_cnt), 64'd1);
        chk("add_back_fetch", 64'(state), 64'd0);

        // Branch taken / not taken: 3 cycles each.
        instr(OP_BRANCH, 1, 0, 0);
        chk("br_t_cycle_cnt", 64'(cycle_cnt), 64'd7);
        instr(OP_BRANCH, 0, 0, 0);
        chk("br_nt_cycle_cnt", 64'(cycle_cnt), 64'd10);
        chk("br_instret", 64'(instret_cnt), 64'd3);

        // LOAD with 3 dmem wait cycles: 8 cycles total.
        instr(OP_LOAD, 0, 0, 3);
        chk("load_cycle_cnt", 64'(cycle_cnt), 64'd18);
        instr(OP_STORE, 0, 0, 0);
        chk("store_cycle_cnt", 64'(cycle_cnt), 64'd22);
        instr(OP_JAL, 0, 2, 0);
        instr(OP_JALR, 1, 0, 0);
        instr(OP_LUI, 0, 0, 0);
        instr(OP_AUIPC, 0, 1, 0);
        chk("mix_instret", 64'(instret_cnt), 64'd9);
        chk("mix_cycle_cnt", 64'(cycle_cnt), 64'd41);

        // Ready exactly when the wait count reaches TIMEOUT: no trap.
        instr(OP_IMM, 0, TIMEOUT, 0);
        chk("edge_ready_cycle_cnt", 64'(cycle_cnt), 64'd61);
        chk("edge_ready_not_halted", 64'(halted), 64'd0);

        // dmem stuck: trap with cause 11, cycle counter frozen.
        instr(OP_LOAD, 0, 0, 99);
        chk("dto_cause", 64'(trap_cause), 64'd3);
        chk("dto_cycle_cnt", 64'(cycle_cnt), 64'd81);
        trap_hold(3);
        chk("dto_frozen", 64'(cycle_cnt), 64'd81);
        do_reset(3'd7);
        chk("rst_cycle_cnt", 64'(cycle_cnt), 64'd0);
        chk("rst_instret", 64'(instret_cnt), 64'd0);

        // imem stuck: trap after 16 wait cycles plus the expiry cycle.
        instr(OP_OP, 0, 99, 0);
        chk("ito_cause", 64'(trap_cause), 64'd2);
        chk("ito_halted", 64'(halted), 64'd1);
        chk("ito_cycle_cnt", 64'(cycle_cnt), 64'd17);
        trap_hold(2);
        do_reset(3'd7);

        // Illegal opcode and SYSTEM halt.
        instr(7'b0000000, 0, 0, 0);
        chk("illegal_cause", 64'(trap_cause), 64'd1);
        trap_hold(2);
        do_reset(3'd7);
        chk("rst_cause", 64'(trap_cause), 64'd0);
        instr(OP_SYSTEM, 0, 0, 0);
        chk("system_state", 64'(state), 64'd7);
        chk("system_cause", 64'(trap_cause), 64'd0);
        trap_hold(2);
        do_reset(3'd7);

        // Reset during MEM of a STORE while dmem_ready arrives.
        opcode = OP_STORE;
        step(mk(3'd0, 1, 1, 0, 0, 0, 0, 0), 1, 1, 0);
        step(mk(3'd1, 0, 0, 0, 0, 0, 0, 0), 1, 1, 0);
        step(mk(3'd2, 0, 0, 0, 0, 0, 0, 0), 1, 1, 0);
        step(mk(3'd3, 0, 0, 1, 1, 0, 0, 0), 1, 0, 0);
        step(mk(3'd3, 0, 0, 1, 1, 0, 0, 0), 0, 1, 1);
        chk("abort_state", 64'(state), 64'd0);
        chk("abort_dmem_req", 64'(bus.dmem_req), 64'd0);
        chk("abort_instret", 64'(instret_cnt), 64'd0);
        step(mk(3'd0, 1, 0, 0, 0, 0, 0, 0), 0, 1, 0);
        step(mk(3'd0, 1, 0, 0, 0, 0, 0, 0), 0, 1, 0);
        chk("late_ready_instret", 64'(instret_cnt), 64'd0);
        instr(OP_OP, 0, 0, 0);
        chk("recover_instret", 64'(instret_cnt), 64'd1);
        chk("recover_cycle_cnt", 64'(cycle_cnt), 64'd6);

        exp_valid = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
